ps2_mouse_init_seq: RTL

//  Host-side command sequencer for a PS/2 mouse. On start, it sends Reset (0xFF), then optionally Set Sample Rate, then Enable Reporting (0xF4).

---
 rtl/ps2_mouse_init_seq.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_init_seq.sv
// rtl/ps2_mouse_init_seq.sv - PS/2 mouse host init sequencer: Reset, optional Set Sample Rate, Enable Reporting
// Optional feature macro: PS2_SETRATE_EN (adds F3 + SAMPLE_RATE between FF and F4).
module ps2_mouse_init_seq #(
    parameter int         RETRY_MAX    = 3,
    parameter int         RESP_TIMEOUT = 1_000_000,
    parameter int         BAT_TIMEOUT  = 25_000_000,
    parameter logic [7:0] SAMPLE_RATE  = 8'd100
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        start,
    output logic [0:10] tx_frame,
    output logic        tx_send,
    input  logic        tx_ok,
    input  logic        tx_err,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  err_code,
    output logic [7:0]  dev_id,
    output logic [7:0]  status
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_TXWAIT = 4'd2,
        ST_ACK    = 4'd3,
        ST_BAT    = 4'd4,
        ST_ID     = 4'd5,
        ST_NEXT   = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } state_t;

    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [24:0]   RESP_LIM  = 25'(RESP_TIMEOUT);
    localparam logic [24:0]   BAT_LIM   = 25'(BAT_TIMEOUT);

    localparam logic [2:0] ERR_RETRY    = 3'd1;
    localparam logic [2:0] ERR_DEV      = 3'd2;
    localparam logic [2:0] ERR_TX_TO    = 3'd3;
    localparam logic [2:0] ERR_REPLY_TO = 3'd4;
    localparam logic [2:0] ERR_BAT      = 3'd5;

    // Full command table; the default build only walks entries 0 and 3.
    localparam logic [7:0] CMD_TABLE [4] = '{8'hFF, 8'hF3, SAMPLE_RATE, 8'hF4};

`ifdef PS2_SETRATE_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    state_t          state;
    logic [1:0]      cmd_idx;
    logic [RW-1:0]   retries;
    logic [24:0]     timer;
    logic            start_q;
    logic            tx_ok_q;
    logic [7:0]      cur_cmd;
    logic            start_rise;
    logic            tx_ok_rise;

    assign start_rise = start & ~start_q;
    assign tx_ok_rise = tx_ok & ~tx_ok_q;
    assign status     = {4'b0000, state};

`ifdef PS2_SETRATE_EN
    assign cur_cmd = CMD_TABLE[cmd_idx];
`else
    assign cur_cmd = (cmd_idx == 2'd0) ? CMD_TABLE[0] : CMD_TABLE[3];
`endif

    // Data bits go LSB-first into the high indices, then odd parity, stop and start.
    function automatic logic [0:10] pack_frame(input logic [7:0] d);
        logic [0:10] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[10-i] = d[i];
        end
        f[2] = ~^d;
        f[1] = 1'b1;
        f[0] = 1'b0;
        return f;
    endfunction

    // Sequencer FSM; all outputs are registered and the timer restarts on every state change.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx_frame <= '0;
            tx_send  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            err_code <= '0;
            dev_id   <= '0;
            cmd_idx  <= '0;
            retries  <= '0;
            timer    <= '0;
            start_q  <= 1'b0;
            tx_ok_q  <= 1'b0;
        end else begin
            start_q <= start;
            tx_ok_q <= tx_ok;
            tx_send <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (start_rise) begin
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        err_code <= '0;
                        cmd_idx  <= '0;
                        retries  <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_frame <= pack_frame(cur_cmd);
                    tx_send  <= 1'b1;
                    timer    <= '0;
                    state    <= ST_TXWAIT;
                end
                ST_TXWAIT: begin
                    // An edge coinciding with the send pulse is stale and is not counted.
                    if (tx_ok_rise && !tx_send) begin
                        timer <= '0;
                        if (!tx_err) begin
                            state <= ST_ACK;
                        end else if (retries < RETRY_LIM) begin
                            retries <= retries + 1'b1;
                            state   <= ST_LOAD;
                        end else begin
                            state    <= ST_FAIL;
                            fail     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_RETRY;
                        end
                    end else if (timer >= RESP_LIM) begin
                        timer    <= '0;
                        state    <= ST_FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_TX_TO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (rx_valid && rx_byte == 8'hFA) begin
                        timer <= '0;
                        state <= (cur_cmd == 8'hFF) ? ST_BAT : ST_NEXT;
                    end else if (rx_valid && rx_byte == 8'hFC) begin
                        timer    <= '0;
                        state    <= ST_FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_DEV;
                    end else if ((rx_valid && rx_byte == 8'hFE) || (!rx_valid && timer >= RESP_LIM)) begin
                        timer <= '0;
                        if (retries < RETRY_LIM) begin
                            retries <= retries + 1'b1;
                            state   <= ST_LOAD;
                        end else begin
                            state    <= ST_FAIL;
                            fail     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_RETRY;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_BAT: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (rx_byte == 8'hAA) begin
                            state <= ST_ID;
                        end else begin
                            state    <= ST_FAIL;
                            fail     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_BAT;
                        end
                    end else if (timer >= BAT_LIM) begin
                        timer    <= '0;
                        state    <= ST_FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_REPLY_TO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_ID: begin
                    if (rx_valid) begin
                        dev_id <= rx_byte;
                        timer  <= '0;
                        state  <= ST_NEXT;
                    end else if (timer >= RESP_LIM) begin
                        timer    <= '0;
                        state    <= ST_FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_REPLY_TO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_NEXT: begin
                    retries <= '0;
                    timer   <= '0;
                    if (cmd_idx == LAST_IDX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cmd_idx <= cmd_idx + 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    timer <= '0;
                    state <= ST_IDLE;
                end
                ST_FAIL: begin
                    timer <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
